// File: rtl/convex_hull_inc.sv
// Incremental 2-D convex hull: one point per handshake, CCW vertex RAM,
// drop stream for evicted/rejected points and a registered readback port.
module convex_hull_inc #(
   parameter int W       = 10,
   parameter int MAX_PTS = 16,
   parameter int IW      = $clog2(MAX_PTS + 1)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          CLR,
   input  logic          PT_VALID,
   output logic          PT_READY,
   input  logic [W-1:0]  PT_X,
   input  logic [W-1:0]  PT_Y,
   output logic          DROP_V,
   output logic [W-1:0]  DROP_X,
   output logic [W-1:0]  DROP_Y,
   output logic [IW-1:0] HULL_CNT,
   output logic          OVF,
   input  logic [IW-1:0] RD_IDX,
   output logic [W-1:0]  RD_X,
   output logic [W-1:0]  RD_Y
);
   localparam int AW = $clog2(MAX_PTS);
   localparam int CW = 2*W + 3;

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_EMIT, S_UPDATE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       vx_q [MAX_PTS];
   logic [W-1:0]       vy_q [MAX_PTS];
   logic [W-1:0]       vx_d [MAX_PTS];
   logic [W-1:0]       vy_d [MAX_PTS];
   logic [IW-1:0]      cnt_q, cnt_d, ncnt_q, ncnt_d;
   logic               ovf_q, ovf_d, rej_q, rej_d, pendp_q, pendp_d, front_q, front_d;
   logic               ready_q;
   logic [W-1:0]       px_q, px_d, py_q, py_d, dx_q, dx_d, dy_q, dy_d, rd_x_q, rd_y_q;
   logic [AW-1:0]      eidx_q, eidx_d, ins_q, ins_d;
   logic [MAX_PTS-1:0] vis_q, vis_d, kill_q, kill_d, pend_q, pend_d;

   logic [AW-1:0]      ia, ib, start_v, sel;
   logic               last_edge, bbox_out, cur_vis, found, rem, drop_v, lo0;
   logic [W-1:0]       ax, ay, bx, by, drop_x, drop_y;
   logic signed [W:0]  ebx, eby, epx, epy;
   logic signed [CW-1:0] cp;
   logic [2*W-1:0]     kp, k0, k1, klo, khi;
   logic [MAX_PTS-1:0] vis_all, kill_v;
   logic [IW:0]        kdrop, newcnt;
   int unsigned        pi, j;

   function automatic logic signed [CW-1:0] sext(input logic signed [W:0] v);
      return {{(CW-W-1){v[W]}}, v};
   endfunction

   // Cross product of edge V[ia]->V[ib] against the latched point
   always_comb begin
      last_edge = (IW'(eidx_q) == cnt_q - IW'(1));
      ia        = eidx_q;
      ib        = last_edge ? '0 : eidx_q + AW'(1);
      ax        = vx_q[ia];
      ay        = vy_q[ia];
      bx        = vx_q[ib];
      by        = vy_q[ib];
      ebx       = $signed({1'b0, bx})   - $signed({1'b0, ax});
      eby       = $signed({1'b0, by})   - $signed({1'b0, ay});
      epx       = $signed({1'b0, px_q}) - $signed({1'b0, ax});
      epy       = $signed({1'b0, py_q}) - $signed({1'b0, ay});
      cp        = sext(ebx) * sext(epy) - sext(eby) * sext(epx);
      bbox_out  = (px_q < ((ax < bx) ? ax : bx)) | (px_q > ((ax < bx) ? bx : ax)) |
                  (py_q < ((ay < by) ? ay : by)) | (py_q > ((ay < by) ? by : ay));
      cur_vis   = cp[CW-1] | ((cp == '0) & bbox_out);
   end

   always_comb begin
      state_d = state_q;  cnt_d   = cnt_q;   ncnt_d  = ncnt_q;  ovf_d   = ovf_q;
      rej_d   = rej_q;    pendp_d = pendp_q; front_d = front_q; px_d    = px_q;
      py_d    = py_q;     dx_d    = dx_q;    dy_d    = dy_q;    eidx_d  = eidx_q;
      ins_d   = ins_q;    vis_d   = vis_q;   kill_d  = kill_q;  pend_d  = pend_q;
      vx_d    = vx_q;     vy_d    = vy_q;
      drop_v  = 1'b0;     drop_x  = dx_q;    drop_y  = dy_q;
      vis_all = vis_q;    vis_all[eidx_q] = cur_vis;
      kill_v  = '0;       start_v = '0;      sel     = '0;      found   = 1'b0;
      rem     = 1'b0;     kdrop   = '0;      newcnt  = '0;      pi      = 0;
      j       = 0;
      kp      = {px_q, py_q};
      k0      = {vx_q[0], vy_q[0]};
      k1      = {vx_q[1], vy_q[1]};
      lo0     = (k0 < k1);
      klo     = lo0 ? k0 : k1;
      khi     = lo0 ? k1 : k0;

      unique case (state_q)
         S_IDLE: begin
            if (CLR) begin
               cnt_d = '0;
               ovf_d = 1'b0;
            end else if (PT_VALID && ready_q) begin
               px_d    = PT_X;  py_d    = PT_Y;
               eidx_d  = '0;    ins_d   = '0;    vis_d  = '0;
               kill_d  = '0;    pend_d  = '0;    rej_d  = 1'b0;
               pendp_d = 1'b0;  front_d = 1'b0;
               state_d = S_EVAL;
            end
         end

         S_EVAL: begin
            if (cnt_q < IW'(3)) begin
               state_d = S_EMIT;
               if (cnt_q == '0) begin
                  front_d = 1'b1;
                  ncnt_d  = IW'(1);
               end else if (cnt_q == IW'(1)) begin
                  ncnt_d = (kp == k0) ? IW'(1) : IW'(2);
                  rej_d  = (kp == k0);
                  pendp_d = (kp == k0);
               end else if (cp == '0) begin
                  // Collinear pair: keep lexicographic extremes, P replaces the middle
                  ncnt_d = IW'(2);
                  if ((kp == k0) || (kp == k1) || ((kp > klo) && (kp < khi))) begin
                     rej_d   = 1'b1;
                     pendp_d = 1'b1;
                  end else begin
                     sel    = ((kp < klo) == lo0) ? AW'(0) : AW'(1);
                     kill_d = MAX_PTS'(1) << sel;
                     pend_d = MAX_PTS'(1) << sel;
                     ins_d  = (sel == '0) ? AW'(1) : AW'(0);
                  end
               end else begin
                  ncnt_d = IW'(3);
                  ins_d  = cp[CW-1] ? AW'(0) : AW'(1);
               end
            end else if (!last_edge) begin
               vis_d  = vis_all;
               eidx_d = eidx_q + AW'(1);
            end else begin
               state_d = S_EMIT;
               vis_d   = vis_all;
               for (int unsigned i = 0; i < MAX_PTS; i++) begin
                  if (i < 32'(cnt_q)) begin
                     pi = (i == 0) ? 32'(cnt_q) - 1 : i - 1;
                     if (vis_all[pi] && vis_all[i]) kill_v[i] = 1'b1;
                     if (vis_all[i] && !vis_all[pi] && !found) begin
                        found   = 1'b1;
                        start_v = AW'(i);
                     end
                  end
               end
               for (int unsigned i = 0; i < MAX_PTS; i++) kdrop = kdrop + (IW+1)'(kill_v[i]);
               newcnt = {1'b0, cnt_q} + (IW+1)'(1) - kdrop;
               if (vis_all == '0) begin
                  rej_d = 1'b1;  pendp_d = 1'b1;  ncnt_d = cnt_q;
               end else if (newcnt > (IW+1)'(MAX_PTS)) begin
                  ovf_d = 1'b1;  rej_d = 1'b1;    pendp_d = 1'b1;  ncnt_d = cnt_q;
               end else begin
                  kill_d = kill_v;  pend_d = kill_v;  ins_d = start_v;
                  ncnt_d = IW'(newcnt);
               end
            end
         end

         S_EMIT: begin
            for (int unsigned i = 0; i < MAX_PTS; i++) begin
               if (pend_q[i] && !found) begin
                  found = 1'b1;
                  sel   = AW'(i);
               end
            end
            if (found) begin
               drop_v      = 1'b1;
               drop_x      = vx_q[sel];
               drop_y      = vy_q[sel];
               pend_d[sel] = 1'b0;
               rem         = ((pend_q & ~(MAX_PTS'(1) << sel)) != '0) || pendp_q;
            end else if (pendp_q) begin
               drop_v  = 1'b1;
               drop_x  = px_q;
               drop_y  = py_q;
               pendp_d = 1'b0;
            end
            if (drop_v) begin
               dx_d = drop_x;
               dy_d = drop_y;
            end
            if (!rem) state_d = S_UPDATE;
         end

         S_UPDATE: begin
            // Rebuild the list: survivors in original order, P after ins_q
            for (int unsigned i = 0; i < MAX_PTS; i++) begin
               vx_d[i] = '0;
               vy_d[i] = '0;
            end
            if (front_q && !rej_q) begin
               vx_d[0] = px_q;
               vy_d[0] = py_q;
               j       = 1;
            end
            for (int unsigned i = 0; i < MAX_PTS; i++) begin
               if (i < 32'(cnt_q)) begin
                  if (!kill_q[i] && (j < MAX_PTS)) begin
                     vx_d[j] = vx_q[i];
                     vy_d[j] = vy_q[i];
                     j       = j + 1;
                  end
                  if ((i == 32'(ins_q)) && !front_q && !rej_q && (j < MAX_PTS)) begin
                     vx_d[j] = px_q;
                     vy_d[j] = py_q;
                     j       = j + 1;
                  end
               end
            end
            cnt_d   = ncnt_q;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;  cnt_q   <= '0;    ncnt_q  <= '0;    ovf_q  <= 1'b0;
         rej_q   <= 1'b0;    pendp_q <= 1'b0;  front_q <= 1'b0;  ready_q <= 1'b0;
         px_q    <= '0;      py_q    <= '0;    dx_q    <= '0;    dy_q   <= '0;
         eidx_q  <= '0;      ins_q   <= '0;    vis_q   <= '0;    kill_q <= '0;
         pend_q  <= '0;      rd_x_q  <= '0;    rd_y_q  <= '0;
         vx_q    <= '{default: '0};
         vy_q    <= '{default: '0};
      end else begin
         state_q <= state_d;  cnt_q   <= cnt_d;    ncnt_q  <= ncnt_d;   ovf_q  <= ovf_d;
         rej_q   <= rej_d;    pendp_q <= pendp_d;  front_q <= front_d;
         ready_q <= (state_d == S_IDLE);
         px_q    <= px_d;     py_q    <= py_d;     dx_q    <= dx_d;     dy_q   <= dy_d;
         eidx_q  <= eidx_d;   ins_q   <= ins_d;    vis_q   <= vis_d;    kill_q <= kill_d;
         pend_q  <= pend_d;   vx_q    <= vx_d;     vy_q    <= vy_d;
         rd_x_q  <= (RD_IDX < cnt_q) ? vx_q[RD_IDX[AW-1:0]] : '0;
         rd_y_q  <= (RD_IDX < cnt_q) ? vy_q[RD_IDX[AW-1:0]] : '0;
      end
   end

   assign PT_READY = ready_q;
   assign DROP_V   = drop_v;
   assign DROP_X   = drop_x;
   assign DROP_Y   = drop_y;
   assign HULL_CNT = cnt_q;
   assign OVF      = ovf_q;
   assign RD_X     = rd_x_q;
   assign RD_Y     = rd_y_q;
endmodule

// File: tb/tb_convex_hull_inc.sv
// Bench for convex_hull_inc: directed hull scenarios plus random points checked
// against a queue-based hull model; readback of every slot after each point.
module tb_convex_hull_inc;
   localparam int W  = 10;
   localparam int MP = 4;
   localparam int IW = $clog2(MP + 1);

   logic          CLK = 1'b0;
   logic          RST_N, CLR, PT_VALID, PT_READY, DROP_V, OVF;
   logic [W-1:0]  PT_X, PT_Y, DROP_X, DROP_Y, RD_X, RD_Y;
   logic [IW-1:0] HULL_CNT, RD_IDX;

   convex_hull_inc #(.W(W), .MAX_PTS(MP)) dut (
      .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .PT_VALID(PT_VALID), .PT_READY(PT_READY),
      .PT_X(PT_X), .PT_Y(PT_Y), .DROP_V(DROP_V), .DROP_X(DROP_X), .DROP_Y(DROP_Y),
      .HULL_CNT(HULL_CNT), .OVF(OVF), .RD_IDX(RD_IDX), .RD_X(RD_X), .RD_Y(RD_Y)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;
   int hx[$], hy[$];
   bit m_ovf;
   int ex_dx[$], ex_dy[$], gdx[$], gdy[$];
   int ex_lat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint xp(int ax, int ay, int bx, int by, int px, int py);
      return longint'(bx - ax) * longint'(py - ay) - longint'(by - ay) * longint'(px - ax);
   endfunction

   // Reference hull update: returns expected drops, latency and new vertex list
   task automatic model(input int px, input int py);
      int n, k, s, mid, sx, sy, less, nx[$], ny[$];
      bit rej, vis[$], kill[$];
      longint c, kk[3];
      n = hx.size();  rej = 0;  k = 0;  s = -1;  mid = -1;
      ex_dx.delete(); ex_dy.delete();
      if (n == 0) begin
         hx.push_back(px); hy.push_back(py);
      end else if (n == 1) begin
         if (px == hx[0] && py == hy[0]) rej = 1;
         else begin hx.push_back(px); hy.push_back(py); end
      end else if (n == 2) begin
         c = xp(hx[0], hy[0], hx[1], hy[1], px, py);
         if (c > 0) begin hx.push_back(px); hy.push_back(py); end
         else if (c < 0) begin hx.insert(1, px); hy.insert(1, py); end
         else begin
            kk[0] = hx[0] * 4096 + hy[0];  kk[1] = hx[1] * 4096 + hy[1];  kk[2] = px * 4096 + py;
            if (kk[2] == kk[0] || kk[2] == kk[1]) rej = 1;
            else begin
               for (int m = 0; m < 3; m++) begin
                  less = 0;
                  for (int o = 0; o < 3; o++) if (kk[o] < kk[m]) less++;
                  if (less == 1) mid = m;
               end
               if (mid == 2) rej = 1;
               else begin
                  ex_dx.push_back(hx[mid]); ex_dy.push_back(hy[mid]);
                  sx = hx[1 - mid]; sy = hy[1 - mid];
                  hx = '{sx, px};   hy = '{sy, py};
               end
            end
         end
      end else begin
         for (int i = 0; i < n; i++) begin
            int b = (i + 1) % n;
            bit outside;
            c = xp(hx[i], hy[i], hx[b], hy[b], px, py);
            outside = (px < ((hx[i] < hx[b]) ? hx[i] : hx[b])) || (px > ((hx[i] > hx[b]) ? hx[i] : hx[b])) ||
                      (py < ((hy[i] < hy[b]) ? hy[i] : hy[b])) || (py > ((hy[i] > hy[b]) ? hy[i] : hy[b]));
            vis.push_back((c < 0) || (c == 0 && outside));
         end
         for (int i = 0; i < n; i++) begin
            kill.push_back(vis[(i + n - 1) % n] && vis[i]);
            if (kill[i]) k++;
            if (vis[i] && !vis[(i + n - 1) % n] && s < 0) s = i;
         end
         if (s < 0 && k == 0) rej = 1;
         else if (n + 1 - k > MP) begin m_ovf = 1; rej = 1; end
         else begin
            if (s < 0) s = 0;
            for (int i = 0; i < n; i++) begin
               if (kill[i]) begin ex_dx.push_back(hx[i]); ex_dy.push_back(hy[i]); end
               else begin nx.push_back(hx[i]); ny.push_back(hy[i]); end
               if (i == s) begin nx.push_back(px); ny.push_back(py); end
            end
            hx = nx; hy = ny;
         end
      end
      if (rej) begin ex_dx.push_back(px); ex_dy.push_back(py); end
      ex_lat = ((n >= 3) ? n : 1) + ((ex_dx.size() > 1) ? ex_dx.size() : 1) + 2;
   endtask

   task automatic send_pt(input int x, input int y);
      int cyc;
      @(negedge CLK);
      model(x, y);
      chk("ready_idle", PT_READY, 1);
      PT_X = W'(x); PT_Y = W'(y); PT_VALID = 1'b1;
      @(posedge CLK); #1 PT_VALID = 1'b0;
      cyc = 1; gdx.delete(); gdy.delete();
      forever begin
         @(negedge CLK);
         if (DROP_V) begin gdx.push_back(int'(DROP_X)); gdy.push_back(int'(DROP_Y)); end
         if (PT_READY || cyc > 200) break;
         @(posedge CLK); cyc++;
      end
      chk("latency", cyc, ex_lat);
      chk("drop_cnt", gdx.size(), ex_dx.size());
      for (int i = 0; i < ex_dx.size() && i < gdx.size(); i++) begin
         chk("drop_x", gdx[i], ex_dx[i]);
         chk("drop_y", gdy[i], ex_dy[i]);
      end
      chk("hull_cnt", HULL_CNT, hx.size());
      chk("ovf", OVF, m_ovf);
      for (int i = 0; i <= MP; i++) begin
         RD_IDX = IW'(i);
         @(posedge CLK); @(negedge CLK);
         chk("rd_x", RD_X, (i < hx.size()) ? hx[i] : 0);
         chk("rd_y", RD_Y, (i < hy.size()) ? hy[i] : 0);
      end
   endtask

   task automatic clear_hull();
      @(negedge CLK); CLR = 1'b1;
      @(posedge CLK); #1 CLR = 1'b0;
      hx.delete(); hy.delete(); m_ovf = 0;
      chk("clr_cnt", HULL_CNT, 0);
      chk("clr_ovf", OVF, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, PT_READY, 0);
      chk({tag, "_dropv"}, DROP_V, 0);
      chk({tag, "_dropx"}, DROP_X, 0);
      chk({tag, "_dropy"}, DROP_Y, 0);
      chk({tag, "_cnt"}, HULL_CNT, 0);
      chk({tag, "_ovf"}, OVF, 0);
      chk({tag, "_rdx"}, RD_X, 0);
      chk({tag, "_rdy"}, RD_Y, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST_N = 1'b0; CLR = 1'b0; PT_VALID = 1'b0; PT_X = '0; PT_Y = '0; RD_IDX = '0;
      #12;
      chk_reset_vals("rst");
      @(negedge CLK) RST_N = 1'b1;
      @(posedge CLK); #1 chk("ready_rel", PT_READY, 1);

      send_pt(0, 0); send_pt(10, 0); send_pt(0, 10);
      chk("tp_tri_cnt", HULL_CNT, 3);
      chk("tp_tri_nodrop", gdx.size(), 0);
      send_pt(2, 2);
      chk("tp_in_drop", (gdx.size() == 1) ? gdx[0] : -1, 2);
      send_pt(10, 10);
      chk("tp_sq_cnt", HULL_CNT, 4);
      send_pt(20, 20);
      chk("tp_evict_x", (gdx.size() == 1) ? gdx[0] : -1, 10);
      chk("tp_evict_cnt", HULL_CNT, 4);

      clear_hull();
      send_pt(0, 0); send_pt(5, 0); send_pt(10, 0);
      chk("tp_col_drop", (gdx.size() == 1) ? gdx[0] : -1, 5);
      chk("tp_col_cnt", HULL_CNT, 2);
      send_pt(5, 0);
      chk("tp_col_mid", (gdx.size() == 1) ? gdx[0] : -1, 5);
      send_pt(0, 0);
      chk("tp_dup", (gdx.size() == 1) ? gdx[0] : -1, 0);

      clear_hull();
      send_pt(0, 0); send_pt(10, 0); send_pt(10, 10); send_pt(0, 10);
      send_pt(20, 5);
      chk("tp_ovf", OVF, 1);
      chk("tp_ovf_drop", (gdx.size() == 1) ? gdx[0] : -1, 20);
      chk("tp_ovf_cnt", HULL_CNT, 4);

      @(negedge CLK); CLR = 1'b1; PT_VALID = 1'b1; PT_X = 10'd7; PT_Y = 10'd7;
      @(posedge CLK); #1 CLR = 1'b0; PT_VALID = 1'b0;
      hx.delete(); hy.delete(); m_ovf = 0;
      chk("clr_prio_cnt", HULL_CNT, 0);
      chk("clr_prio_ovf", OVF, 0);
      chk("clr_prio_ready", PT_READY, 1);

      send_pt(0, 0); send_pt(10, 0); send_pt(0, 10);
      @(negedge CLK); PT_X = 10'd30; PT_Y = 10'd30; PT_VALID = 1'b1;
      @(posedge CLK); #1 PT_VALID = 1'b0;
      #2 RST_N = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge CLK) RST_N = 1'b1;
      hx.delete(); hy.delete(); m_ovf = 0;
      @(posedge CLK); #1 chk("midrst_ready_rel", PT_READY, 1);
      chk("midrst_cnt_rel", HULL_CNT, 0);

      for (int r = 0; r < 8; r++) begin
         if (r > 0) clear_hull();
         for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 4) == 0) send_pt($urandom_range(0, 1023), $urandom_range(0, 1023));
            else send_pt($urandom_range(0, 12), $urandom_range(0, 12));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
